line_step_ctrl: RTL and testbench

- Sequencing FSM for the Bresenham error/y datapath (error_datapath) in the line rasteriser.
- Latches a line's x span on `start` and initialises the error and y registers through the datapath mux/write-enable controls.
- Steps `xcount` from x0 to x1 and presents one pixel per x to the downstream pixel writer with a valid/ready handshake.
- Upstream (octant/swap logic) supplies x0 <= x1 and drives deltax, deltay, y0 and ystep straight into the datapath.

---
 rtl/line_step_ctrl_if.sv | 11 +
 rtl/line_step_ctrl.sv | 179 +++++++++++++++++
 tb/tb_line_step_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_step_ctrl_if.sv
// Pixel handshake bundle between the line stepper and the downstream pixel writer.
interface line_step_ctrl_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] xcount;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output xcount, output pix_valid, input pix_ready);
    modport slave  (input xcount, input pix_valid, output pix_ready);
endinterface

// File: rtl/line_step_ctrl.sv
// Bresenham sequencing FSM: steps x across a line and drives the error/y datapath controls.
// Optional LINE_ABORT_EN adds an abort input that drops any active line back to IDLE.
//
// state | meaning
// IDLE  | waiting for start
// ERR   | rejected span (x1 < x0), line_err pulse
// INIT  | load error_init into error reg and y0 into y reg
// EMIT  | present (xcount, y) until the writer accepts it
// ADJ   | error += deltax, y += ystep
// DEC   | error -= deltay, xcount++
// DONE  | done pulse
module line_step_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LINE_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] x0_in,
    input  logic [WIDTH-1:0] x1_in,
    output logic             busy,
    output logic             done,
    output logic             line_err,
    output logic [WIDTH-1:0] x0,
    input  logic             less_than_zero,
    output logic             WE_error_reg,
    output logic             WE_y_reg,
    output logic             e_sel_mux_in,
    output logic             e_sel_mux_out,
    output logic             y_sel_mux_in,
    line_step_ctrl_if.master pix
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_INIT,
        S_EMIT,
        S_ADJ,
        S_DEC,
        S_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic line_err;
        logic we_e;
        logic we_y;
        logic e_in;
        logic e_out;
        logic y_in;
        logic valid;
    } ctl_t;

    state_t           state;
    ctl_t             ctl;
    logic [WIDTH-1:0] x0_q;
    logic [WIDTH-1:0] x1_q;
    logic [WIDTH-1:0] xcount_q;

    // Outputs are registered alongside the state, so decode the state being entered.
    function automatic ctl_t dec(input state_t s);
        ctl_t c;
        c = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_ERR:  c.line_err = 1'b1;
            S_INIT: begin
                c.we_e = 1'b1;
                c.we_y = 1'b1;
            end
            S_EMIT: c.valid = 1'b1;
            S_ADJ:  begin
                c.we_e  = 1'b1;
                c.e_in  = 1'b1;
                c.e_out = 1'b1;
                c.we_y  = 1'b1;
                c.y_in  = 1'b1;
            end
            S_DEC:  begin
                c.we_e = 1'b1;
                c.e_in = 1'b1;
            end
            S_DONE: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ctl      <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            xcount_q <= '0;
        end
`ifdef LINE_ABORT_EN
        else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            ctl   <= dec(S_IDLE);
        end
`endif
        else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (x1_in >= x0_in) begin
                            x0_q     <= x0_in;
                            x1_q     <= x1_in;
                            xcount_q <= x0_in;
                            state    <= S_INIT;
                            ctl      <= dec(S_INIT);
                        end else begin
                            state <= S_ERR;
                            ctl   <= dec(S_ERR);
                        end
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                    ctl   <= dec(S_IDLE);
                end
                S_INIT: begin
                    state <= S_EMIT;
                    ctl   <= dec(S_EMIT);
                end
                S_EMIT: begin
                    // Terminate on equality before any increment so x1 = all-ones never wraps.
                    if (pix.pix_ready) begin
                        if (xcount_q == x1_q) begin
                            state <= S_DONE;
                            ctl   <= dec(S_DONE);
                        end else if (less_than_zero) begin
                            state <= S_ADJ;
                            ctl   <= dec(S_ADJ);
                        end else begin
                            state <= S_DEC;
                            ctl   <= dec(S_DEC);
                        end
                    end
                end
                S_ADJ: begin
                    state <= S_DEC;
                    ctl   <= dec(S_DEC);
                end
                S_DEC: begin
                    xcount_q <= xcount_q + 1'b1;
                    state    <= S_EMIT;
                    ctl      <= dec(S_EMIT);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ctl   <= dec(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= '0;
                end
            endcase
        end
    end

    assign busy          = ctl.busy;
    assign done          = ctl.done;
    assign line_err      = ctl.line_err;
    assign WE_error_reg  = ctl.we_e;
    assign WE_y_reg      = ctl.we_y;
    assign e_sel_mux_in  = ctl.e_in;
    assign e_sel_mux_out = ctl.e_out;
    assign y_sel_mux_in  = ctl.y_in;
    assign x0            = x0_q;
    assign pix.xcount    = xcount_q;
    assign pix.pix_valid = ctl.valid;

endmodule

// File: tb/tb_line_step_ctrl.sv
// Bench for line_step_ctrl: table of lines with hand-computed pixels plus reset/abort sequences.
module tb_line_step_ctrl;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x0_in = '0;
    logic [WIDTH-1:0] x1_in = '0;
    logic             busy, done, line_err;
    logic [WIDTH-1:0] x0;
    logic             less_than_zero;
    logic             WE_error_reg, WE_y_reg, e_sel_mux_in, e_sel_mux_out, y_sel_mux_in;
`ifdef LINE_ABORT_EN
    logic             abort = 1'b0;
`endif

    line_step_ctrl_if #(.WIDTH(WIDTH)) pif ();

    line_step_ctrl #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef LINE_ABORT_EN
        .abort          (abort),
`endif
        .start          (start),
        .x0_in          (x0_in),
        .x1_in          (x1_in),
        .busy           (busy),
        .done           (done),
        .line_err       (line_err),
        .x0             (x0),
        .less_than_zero (less_than_zero),
        .WE_error_reg   (WE_error_reg),
        .WE_y_reg       (WE_y_reg),
        .e_sel_mux_in   (e_sel_mux_in),
        .e_sel_mux_out  (e_sel_mux_out),
        .y_sel_mux_in   (y_sel_mux_in),
        .pix            (pif)
    );

    always #5 clk = ~clk;

    // Stand-in for the error/y datapath, driven only by the controller's enables and selects.
    int               dx_v = 0;
    int               dy_v = 0;
    logic [WIDTH-1:0] y0_v = '0;
    logic [WIDTH-1:0] ystep_v = '0;
    int               err = 0;
    logic [WIDTH-1:0] y_reg = '0;

    assign less_than_zero = (err < 0);

    always @(posedge clk) begin
        if (WE_error_reg)
            err <= e_sel_mux_in ? (e_sel_mux_out ? err + dx_v : err - dy_v) : (dx_v / 2 - dy_v);
        if (WE_y_reg)
            y_reg <= y_sel_mux_in ? y_reg + ystep_v : y0_v;
    end

    typedef struct {
        logic [WIDTH-1:0]            x0;
        logic [WIDTH-1:0]            x1;
        logic [WIDTH-1:0]            y0;
        int                          dx;
        int                          dy;
        logic [WIDTH-1:0]            ystep;
        bit                          exp_err;
        int                          exp_cyc;
        int                          npix;
        logic [7:0][WIDTH-1:0]       ys;
        int                          ywr;
        bit                          stall;
        bit                          noise;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int yy, input int dx, input int dy,
                                input int ys, input bit e, input int cyc, input int n,
                                input int p0, input int p1, input int p2, input int p3,
                                input int p4, input int p5, input int ywr, input bit st,
                                input bit nz);
        vec_t v;
        v.x0 = WIDTH'(a); v.x1 = WIDTH'(b); v.y0 = WIDTH'(yy);
        v.dx = dx; v.dy = dy; v.ystep = WIDTH'(ys);
        v.exp_err = e; v.exp_cyc = cyc; v.npix = n;
        v.ys = '0;
        v.ys[0] = WIDTH'(p0); v.ys[1] = WIDTH'(p1); v.ys[2] = WIDTH'(p2);
        v.ys[3] = WIDTH'(p3); v.ys[4] = WIDTH'(p4); v.ys[5] = WIDTH'(p5);
        v.ywr = ywr; v.stall = st; v.noise = nz;
        return v;
    endfunction

    task automatic begin_line(input vec_t v);
        dx_v = v.dx; dy_v = v.dy; y0_v = v.y0; ystep_v = v.ystep;
        x0_in = v.x0; x1_in = v.x1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_line(input vec_t v, input string tag);
        int cyc, npix, ywr, stalls;
        begin_line(v);
        cyc = 1; npix = 0; ywr = 0; stalls = 0;
        pif.pix_ready = 1'b1;
        if (!v.exp_err)
            chk({tag, " init ctl"}, {WE_error_reg, WE_y_reg, e_sel_mux_in, y_sel_mux_in}, 4'b1100);
        while (!done && !line_err && cyc < 60) begin
            if (WE_y_reg) ywr++;
            if (pif.pix_valid) begin
                if (v.stall && npix == 2 && stalls < 3) begin
                    pif.pix_ready = 1'b0;
                    stalls++;
                    chk({tag, " stall x"}, pif.xcount, v.x0 + 2);
                    chk({tag, " stall y"}, y_reg, v.ys[2]);
                end else begin
                    pif.pix_ready = 1'b1;
                    if (npix < v.npix) begin
                        chk({tag, " pix x"}, pif.xcount, v.x0 + WIDTH'(npix));
                        chk({tag, " pix y"}, y_reg, v.ys[npix]);
                    end
                    npix++;
                end
            end
            start = v.noise;
            if (v.noise) begin x0_in = 5; x1_in = 6; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pif.pix_ready = 1'b1;
        chk({tag, " end pulse"}, {done, line_err}, v.exp_err ? 2'b01 : 2'b10);
        chk({tag, " cycles"}, cyc, v.exp_cyc);
        chk({tag, " pixels"}, npix, v.npix);
        chk({tag, " y writes"}, ywr, v.ywr);
        chk({tag, " busy at end"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, " idle after"}, {busy, done, line_err, pif.pix_valid}, 4'b0000);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, line_err, x0, pif.xcount, pif.pix_valid, WE_error_reg, WE_y_reg,
                   e_sel_mux_in, e_sel_mux_out, y_sel_mux_in}, 32'd0);
    endtask

    initial begin
        int n;
        pif.pix_ready = 1'b1;
        //           x0    x1    y0 dx dy ys  err cyc n   y pixels            ywr st nz
        vecs[0] = mk(0,    4,    0, 4, 2, 1,  0, 13, 5,  0, 0, 1, 1, 2, 0,  3, 0, 0);
        vecs[1] = mk(7,    7,    3, 0, 0, 1,  0, 3,  1,  3, 0, 0, 0, 0, 0,  1, 0, 0);
        vecs[2] = mk(3,    8,    5, 5, 2, -1, 0, 15, 6,  5, 5, 4, 4, 3, 3,  3, 0, 0);
        vecs[3] = mk(0,    4,    0, 4, 4, 1,  0, 15, 5,  0, 1, 2, 3, 4, 0,  5, 0, 0);
        vecs[4] = mk(9,    4,    0, 0, 0, 1,  1, 1,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[5] = mk(1021, 1023, 7, 2, 0, 1,  0, 7,  3,  7, 7, 7, 0, 0, 0,  1, 0, 0);
        vecs[6] = mk(0,    2,    0, 2, 0, 1,  0, 7,  3,  0, 0, 0, 0, 0, 0,  1, 0, 0);
        vecs[7] = mk(0,    4,    0, 4, 2, 1,  0, 16, 5,  0, 0, 1, 1, 2, 0,  3, 1, 1);

        start = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset outputs");
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle outputs");

        for (int i = 0; i < 8; i++)
            run_line(vecs[i], $sformatf("line%0d", i));

        // Reset in the cycle after the second pixel handshake.
        begin_line(vecs[0]);
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (pif.pix_valid) n++;
            @(negedge clk);
        end
        chk("rst pixels before", n, 2);
        chk("rst pre busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst mid-line");
        @(negedge clk);
        chk("rst no done", {done, busy}, 2'b00);
        run_line(vecs[0], "after rst");

`ifdef LINE_ABORT_EN
        begin_line(vecs[0]);
        n = 0;
        for (int c = 0; c < 40 && !(pif.pix_valid && pif.xcount == 2); c++) begin
            n++;
            @(negedge clk);
        end
        chk("abort reached x2", {pif.pix_valid, pif.xcount}, {1'b1, 10'd2});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort idle", {busy, done, line_err, pif.pix_valid, WE_error_reg, WE_y_reg}, 6'd0);
        @(negedge clk);
        chk("abort no done", {done, busy}, 2'b00);
        run_line(vecs[6], "after abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
